// File: rtl/sample_in_ball.sv
// rtl/sample_in_ball.sv - ML-DSA SampleInBall challenge sampler fed by SHAKE256 squeeze blocks
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             one-cycle pulse starting a run (ignored while busy)
//   ml_dsa_level      00: tau=39, 01: tau=49, 10/11: tau=60 (sampled on accepted start)
//   keccak_output     H core state; bits [1087:0] are the rate block, byte k = [8k+7:8k]
//   block_valid       keccak_output holds a fresh squeeze block this cycle
//   block_req         one-cycle pulse asking the H core for the next squeeze block
//   c_out             challenge polynomial, coefficient n in [2n+1:2n] (00=0, 01=+1, 11=-1)
//   busy              high from accepted start until done
//   done              one-cycle pulse; c_out is final
//   rej_count         (SAMPLE_IN_BALL_STATS_EN only) rejected bytes in the last run
//   blk_count         (SAMPLE_IN_BALL_STATS_EN only) blocks consumed in the last run
//
// Optional feature macro: SAMPLE_IN_BALL_STATS_EN
module sample_in_ball (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    ml_dsa_level,
    input  logic [1599:0] keccak_output,
    input  logic          block_valid,
    output logic          block_req,
    output logic [511:0]  c_out,
    output logic          busy,
    output logic          done
`ifdef SAMPLE_IN_BALL_STATS_EN
    ,
    output logic [15:0]   rej_count,
    output logic [7:0]    blk_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BLK,
        SIGN,
        SAMPLE,
        DONE
    } state_t;

    state_t         state;
    logic [1087:0]  blk;        // current rate block, shifted so the next byte is always blk[7:0]
    logic [63:0]    h;          // sign bits, shifted so the next sign is always h[0]
    logic [7:0]     p;          // byte pointer within the current block (0..135)
    logic [7:0]     i;          // SampleInBall loop index, starts at 256 - tau
    logic           first_blk;  // next latched block is the first of the run (carries the sign bits)
    logic [511:0]   c;

    logic [7:0]     byte_j;
    logic           accept;
    logic [7:0]     i_start;

    // The capacity part of the Keccak state is never used by this block.
    logic unused_keccak_capacity;
    assign unused_keccak_capacity = ^keccak_output[1599:1088];

    assign byte_j = blk[7:0];
    assign accept = (byte_j <= i);
    assign c_out  = c;

    // i starts at 256 - tau; level 11 behaves as level 10.
    always_comb begin
        i_start = 8'd196;
        case (ml_dsa_level)
            2'b00:   i_start = 8'd217;
            2'b01:   i_start = 8'd207;
            default: i_start = 8'd196;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            blk       <= '0;
            h         <= '0;
            p         <= '0;
            i         <= '0;
            first_blk <= 1'b0;
            c         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            block_req <= 1'b0;
`ifdef SAMPLE_IN_BALL_STATS_EN
            rej_count <= '0;
            blk_count <= '0;
`endif
        end else begin
            block_req <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        c         <= '0;
                        i         <= i_start;
                        p         <= '0;
                        first_blk <= 1'b1;
                        busy      <= 1'b1;
                        state     <= WAIT_BLK;
`ifdef SAMPLE_IN_BALL_STATS_EN
                        rej_count <= '0;
                        blk_count <= '0;
`endif
                    end
                end
                WAIT_BLK: begin
                    if (block_valid) begin
                        blk       <= keccak_output[1087:0];
                        p         <= '0;
                        first_blk <= 1'b0;
                        state     <= first_blk ? SIGN : SAMPLE;
`ifdef SAMPLE_IN_BALL_STATS_EN
                        blk_count <= blk_count + 8'd1;
`endif
                    end
                end
                SIGN: begin
                    h     <= blk[63:0];
                    blk   <= blk >> 64;
                    p     <= 8'd8;
                    state <= SAMPLE;
                end
                SAMPLE: begin
                    blk <= blk >> 8;
                    p   <= p + 8'd1;
                    if (accept) begin
                        // Both writes target c; when j == i the second one wins,
                        // leaving c[i] equal to the sign value.
                        c[{i, 1'b0} +: 2]      <= c[{byte_j, 1'b0} +: 2];
                        c[{byte_j, 1'b0} +: 2] <= h[0] ? 2'b11 : 2'b01;
                        h <= h >> 1;
                        i <= i + 8'd1;
                    end
`ifdef SAMPLE_IN_BALL_STATS_EN
                    else begin
                        rej_count <= rej_count + 16'd1;
                    end
`endif
                    if (accept && (i == 8'd255)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (p == 8'd135) begin
                        block_req <= 1'b1;
                        state     <= WAIT_BLK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_in_ball.sv
// tb/tb_sample_in_ball.sv - table-driven self-checking bench for sample_in_ball
module tb_sample_in_ball;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    ml_dsa_level = 2'd0;
    logic [1599:0] keccak_output = '0;
    logic          block_valid = 1'b0;
    logic          block_req;
    logic [511:0]  c_out;
    logic          busy;
    logic          done;
`ifdef SAMPLE_IN_BALL_STATS_EN
    logic [15:0]   rej_count;
    logic [7:0]    blk_count;
`endif

    sample_in_ball dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .ml_dsa_level  (ml_dsa_level),
        .keccak_output (keccak_output),
        .block_valid   (block_valid),
        .block_req     (block_req),
        .c_out         (c_out),
        .busy          (busy),
        .done          (done)
`ifdef SAMPLE_IN_BALL_STATS_EN
        ,
        .rej_count     (rej_count),
        .blk_count     (blk_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [1087:0] blocks [0:7];

    typedef struct {
        string          name;
        logic [1:0]     lvl;
        logic [1087:0]  b0;
        logic [1087:0]  b1;
        logic [511:0]   exp_c;
        int             exp_lat;
        int             exp_reqs;
        int             exp_rej;
        int             exp_blk;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [1087:0] set_byte(input logic [1087:0] b, input int k, input logic [7:0] v);
        b[8*k +: 8] = v;
        return b;
    endfunction

    function automatic logic [511:0] set_coef(input logic [511:0] cc, input int n, input logic [1:0] v);
        cc[2*n +: 2] = v;
        return cc;
    endfunction

    // Reference SampleInBall over the blocks[] stream (sign bits from block 0 bytes 0..7).
    function automatic void model(input int tau, output logic [511:0] cexp, output int nblk, output int rej);
        int            cc [256];
        logic [63:0]   hh;
        logic [1087:0] cb;
        int            bi, p, j;
        for (int k = 0; k < 256; k++) cc[k] = 0;
        hh  = blocks[0][63:0];
        bi  = 0;
        p   = 8;
        rej = 0;
        for (int i = 256 - tau; i < 256; i++) begin
            do begin
                if (p == 136) begin bi++; p = 0; end
                cb = (bi < 8) ? blocks[bi] : '0;
                j = int'(cb[8*p +: 8]);
                p++;
                if (j > i) rej++;
            end while (j > i);
            cc[i] = cc[j];
            cc[j] = hh[i + tau - 256] ? -1 : 1;
        end
        nblk = bi + 1;
        cexp = '0;
        for (int k = 0; k < 256; k++)
            cexp[2*k +: 2] = (cc[k] == 1) ? 2'b01 : (cc[k] == -1) ? 2'b11 : 2'b00;
    endfunction

    task automatic present(input logic [1087:0] b, output int tbv);
        keccak_output = {{512{1'b1}}, b};
        block_valid   = 1'b1;
        tbv           = cyc;
        @(negedge clk);
        block_valid   = 1'b0;
    endtask

    // Runs one sampling pass; answers block_req after a 3-cycle H latency.
    // lat is measured from the last block_valid cycle to the done cycle.
    task automatic do_run(input logic [1:0] lvl, input int poke, output int lat, output int reqs);
        int bi, tbv;
        bit fin;
        reqs = 0; lat = -1; bi = 0; fin = 1'b0;
        @(negedge clk);
        start = 1'b1; ml_dsa_level = lvl;
        @(negedge clk);
        start = 1'b0; ml_dsa_level = 2'd0;
        chk("busy_rise", 512'(busy), 512'd1);
        present(blocks[0], tbv);
        for (int t = 0; t < 3000 && !fin; t++) begin
            start = (t == poke);
            if (t == poke) ml_dsa_level = 2'd2;
            if (done) begin
                fin = 1'b1;
                lat = cyc - tbv;
            end else if (block_req) begin
                reqs++;
                bi++;
                repeat (3) @(negedge clk);
                present((bi < 8) ? blocks[bi] : '0, tbv);
            end else begin
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!fin) begin
            n_chk++;
            $display("FAIL run_timeout: got no done expected done within bound");
        end
    endtask

    initial begin
        logic [511:0] e;
        logic [511:0] cexp;
        logic [1087:0] b;
        int lat, reqs, nblk, rej, cnt, dummy;

        // ---- vector table ----
        e = set_coef('0, 0, 2'b01);
        for (int n = 218; n < 256; n++) e = set_coef(e, n, 2'b01);
        vt[0] = '{"lvl0_zero", 2'd0, '0, '0, e, 41, 0, 0, 1};

        b = '0;
        for (int k = 0; k < 8; k++) b = set_byte(b, k, 8'hFF);
        for (int k = 0; k < 39; k++) b = set_byte(b, 8 + k, 8'(217 + k));
        e = '0;
        for (int n = 217; n < 256; n++) e = set_coef(e, n, 2'b11);
        vt[1] = '{"lvl0_neg", 2'd0, b, '0, e, 41, 0, 0, 1};

        b = '0;
        for (int k = 8; k < 136; k++) b = set_byte(b, k, 8'hFF);
        vt[2].b0 = b;
        b = '0;
        for (int k = 0; k < 49; k++) b = set_byte(b, k, 8'(207 + k));
        e = '0;
        for (int n = 207; n < 256; n++) e = set_coef(e, n, 2'b01);
        vt[2] = '{"lvl1_rej", 2'd1, vt[2].b0, b, e, 50, 1, 128, 2};

        e = set_coef('0, 0, 2'b01);
        for (int n = 208; n < 256; n++) e = set_coef(e, n, 2'b01);
        vt[3] = '{"lvl1_zero", 2'd1, '0, '0, e, 51, 0, 0, 1};

        e = set_coef('0, 0, 2'b01);
        for (int n = 197; n < 256; n++) e = set_coef(e, n, 2'b01);
        vt[4] = '{"lvl2_zero", 2'd2, '0, '0, e, 62, 0, 0, 1};
        vt[5] = '{"lvl3_zero", 2'd3, '0, '0, e, 62, 0, 0, 1};

        for (int k = 0; k < 8; k++) blocks[k] = '0;

        // ---- reset state ----
        #1;
        chk("reset_ctl", 512'({busy, done, block_req}), 512'd0);
        chk("reset_c", c_out, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- table-driven runs ----
        for (int v = 0; v < 6; v++) begin
            blocks[0] = vt[v].b0;
            blocks[1] = vt[v].b1;
            do_run(vt[v].lvl, -1, lat, reqs);
            chk({vt[v].name, "_c"},    c_out, vt[v].exp_c);
            chk({vt[v].name, "_lat"},  512'(lat), 512'(vt[v].exp_lat));
            chk({vt[v].name, "_reqs"}, 512'(reqs), 512'(vt[v].exp_reqs));
`ifdef SAMPLE_IN_BALL_STATS_EN
            chk({vt[v].name, "_rej"},  512'(rej_count), 512'(vt[v].exp_rej));
            chk({vt[v].name, "_blk"},  512'(blk_count), 512'(vt[v].exp_blk));
`endif
            @(negedge clk);
            chk({vt[v].name, "_done_pulse"}, 512'({done, busy}), 512'd0);
            chk({vt[v].name, "_c_hold"}, c_out, vt[v].exp_c);
        end

        // ---- start while busy is ignored ----
        blocks[0] = vt[0].b0;
        blocks[1] = '0;
        do_run(2'd0, 5, lat, reqs);
        chk("busy_start_c", c_out, vt[0].exp_c);
        chk("busy_start_lat", 512'(lat), 512'd41);

        // ---- random stream, level 10, against reference model ----
        for (int k = 0; k < 8; k++)
            for (int w = 0; w < 34; w++) blocks[k][32*w +: 32] = $urandom;
        model(60, cexp, nblk, rej);
        do_run(2'd2, -1, lat, reqs);
        chk("rand_c", c_out, cexp);
        chk("rand_reqs", 512'(reqs), 512'(nblk - 1));
        cnt = 0;
        for (int n = 0; n < 256; n++) if (c_out[2*n +: 2] != 2'b00) cnt++;
        chk("rand_weight", 512'(cnt), 512'd60);
`ifdef SAMPLE_IN_BALL_STATS_EN
        chk("rand_rej", 512'(rej_count), 512'(rej));
        chk("rand_blk", 512'(blk_count), 512'(nblk));
`endif

        // ---- reset in the middle of SAMPLE ----
        b = '0;
        for (int k = 20; k < 136; k++) b = set_byte(b, k, 8'hFF);
        @(negedge clk);
        start = 1'b1; ml_dsa_level = 2'd0;
        @(negedge clk);
        start = 1'b0;
        present(b, dummy);
        repeat (8) @(negedge clk);
        chk("mid_run_busy", 512'({busy, c_out != '0}), 512'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_ctl", 512'({busy, done, block_req}), 512'd0);
        chk("mid_reset_c", c_out, '0);
`ifdef SAMPLE_IN_BALL_STATS_EN
        chk("mid_reset_stats", 512'({rej_count, blk_count}), 512'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        blocks[0] = vt[1].b0;
        do_run(2'd0, -1, lat, reqs);
        chk("post_reset_c", c_out, vt[1].exp_c);
        chk("post_reset_lat", 512'(lat), 512'd41);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sample_in_ball.md
# sample_in_ball

Consumes the SHAKE256 squeeze blocks produced by the H-function core and performs ML-DSA SampleInBall (FIPS 204, Alg. 29), producing the sparse challenge polynomial c with exactly tau coefficients of ±1. Sits directly downstream of the H core: latches each 1088-bit rate block on `block_valid`, walks it byte by byte, and pulses `block_req` to squeeze the next block when the current one is exhausted.

## Interface
- No parameters; tau is selected at run time by `ml_dsa_level`.
- `clk` in 1 — system clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `start` in 1 — one-cycle pulse; begins a sampling run (ignored while `busy`).
- `ml_dsa_level` in 2 — 00: ML-DSA-44 (tau=39); 01: ML-DSA-65 (tau=49); 10: ML-DSA-87 (tau=60); 11: treated as 10. Sampled on accepted `start`.
- `keccak_output` in 1600 — H core state; bits [1087:0] are the rate block; byte k = bits [8k+7:8k].
- `block_valid` in 1 — H core done; `keccak_output` valid this cycle.
- `block_req` out 1 — one-cycle pulse requesting the next squeeze.
- `c_out` out 512 — coefficient n in bits [2n+1:2n]: 00=0, 01=+1, 11=−1.
- `busy` out 1 — high from accepted `start` until `done`.
- `done` out 1 — one-cycle pulse; `c_out` final.

## Operation
- States: IDLE, WAIT_BLK, SIGN, SAMPLE, DONE.
- IDLE/DONE + `start`: clear coefficient array to 0, latch tau, set i = 256−tau, byte pointer p = 0, go WAIT_BLK.
- WAIT_BLK: on `block_valid`, latch `keccak_output[1087:0]` into block buffer, p = 0; go SIGN on first block of the run, else SAMPLE.
- SIGN: h[63:0] = bytes 0..7 (byte 0 = h[7:0]); p = 8; go SAMPLE.
- SAMPLE, one byte per cycle: j = byte[p], p++.
  - j > i: reject, no array update.
  - j ≤ i: c[i] ← c[j]; c[j] ← (h[i+tau−256] ? −1 : +1); i++. Read of c[j] uses pre-update value; when j = i the result is c[i] = sign value.
  - After accepted byte with i = 255: go DONE.
  - If p becomes 136 and run not complete: pulse `block_req`, go WAIT_BLK.
- DONE: `done` high one cycle, then IDLE. `c_out` holds until next accepted `start`.
- `block_valid` outside WAIT_BLK is ignored.
- Exactly tau nonzero coefficients at completion.

## Timing
- Reset: `c_out`=0, `busy`=0, `done`=0, `block_req`=0, state IDLE; all counters/buffers 0. Reset mid-run aborts immediately; no `done`.
- `busy` rises the cycle after `start`.
- `block_req` asserted in the cycle after byte 135 is consumed; never asserted for the first block (upstream H produces it from its own start).
- Latency with no rejections and single block: `done` = cycle of `block_valid` + 1 (SIGN) + tau (SAMPLE) + 1. Each rejected byte adds 1 cycle; each extra block adds 1 + H latency.
- `start` while `busy`: ignored, no effect on state or outputs.

## Configuration
- `SAMPLE_IN_BALL_STATS_EN` defined: adds outputs `rej_count` (16, rejected bytes in last run) and `blk_count` (8, blocks consumed incl. first); both clear on accepted `start`, reset to 0, hold after `done`.
- Undefined: ports and counters absent; remaining behaviour identical.

## Test plan
- Level 00, all block bytes 0x00 → c[0]=+1, c[217]=0, c[218..255]=+1, all others 0 (39 nonzero); `done` at block_valid+41 cycles; zero `block_req`.
- Level 00, bytes 0–7 = 0xFF, byte 8+k = 217+k → c[217..255] = −1 (11), rest 0.
- Level 01, bytes 8..135 = 0xFF (all rejected since i=207) → one `block_req` pulse; second block bytes 0.. = 207+k → c[207..255] = +1 (h=0); with stats: rej_count=128, blk_count=2.
- Level 10, random block stream from H model → popcount of nonzero = 60, `c_out` matches software SampleInBall.
- Assert `rst_n`=0 mid-SAMPLE → `busy`,`done`,`block_req`,`c_out` all 0 next edge; subsequent run correct.
- `start` pulsed while `busy` → ignored; run completes with original tau and result unchanged.
